fetch_unit: RTL

Instruction fetch stage for the RISC-V core. It sits directly upstream of the unified instruction/data RAM's instruction port. It owns the program counter, drives the RAM's word-indexed instruction address, and absorbs the RAM's one-cycle registered read latency and lost reads during store cycles. It delivers (pc, instruction) pairs to decode over a valid/ready handshake, through a 2-entry output buffer, with redirect support for branches and jumps.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word reads to the
// instruction RAM and buffers returned (pc, instr) pairs for decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_wr_busy,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready
);

   function automatic logic [31:0] word_align(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

   function automatic logic [31:0] pc_incr(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // p0: next fetch address
   logic [31:0] fetch_pc_p0;

   // p1: read outstanding at the RAM, data arrives this cycle
   logic        vld_p1;
   logic [31:0] pc_p1;

   // p2: two-entry output buffer, slot 0 is the head; tail is kept zero unless count is 2
   logic [1:0]  count_p2;
   logic        vld_p2;
   logic [31:0] head_pc_p2;
   logic [31:0] head_instr_p2;
   logic [31:0] tail_pc_p2;
   logic [31:0] tail_instr_p2;

   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occupancy;

   logic [1:0]  count_nxt;
   logic [31:0] head_pc_nxt;
   logic [31:0] head_instr_nxt;
   logic [31:0] tail_pc_nxt;
   logic [31:0] tail_instr_nxt;

   assign mem_addr  = {2'b00, fetch_pc_p0[31:2]};
   assign out_valid = vld_p2;
   assign out_pc    = head_pc_p2;
   assign out_instr = head_instr_p2;

   assign pop       = vld_p2 && out_ready;
   assign push      = vld_p1;
   assign occupancy = {1'b0, count_p2} + {2'b00, vld_p1};
   // Issuing only when a slot is guaranteed free keeps the buffer from overflowing.
   assign issue     = !rst && !redirect_valid && !mem_wr_busy &&
                      ((occupancy < 3'd2) || pop);

   always_comb begin
      count_nxt      = count_p2;
      head_pc_nxt    = head_pc_p2;
      head_instr_nxt = head_instr_p2;
      tail_pc_nxt    = tail_pc_p2;
      tail_instr_nxt = tail_instr_p2;
      case ({pop, push})
         2'b10: begin
            head_pc_nxt    = tail_pc_p2;
            head_instr_nxt = tail_instr_p2;
            tail_pc_nxt    = 32'd0;
            tail_instr_nxt = 32'd0;
            count_nxt      = count_p2 - 2'd1;
         end
         2'b01: begin
            if (count_p2 == 2'd0) begin
               head_pc_nxt    = pc_p1;
               head_instr_nxt = mem_data;
            end else begin
               tail_pc_nxt    = pc_p1;
               tail_instr_nxt = mem_data;
            end
            count_nxt = count_p2 + 2'd1;
         end
         2'b11: begin
            if (count_p2 == 2'd2) begin
               head_pc_nxt    = tail_pc_p2;
               head_instr_nxt = tail_instr_p2;
               tail_pc_nxt    = pc_p1;
               tail_instr_nxt = mem_data;
            end else begin
               head_pc_nxt    = pc_p1;
               head_instr_nxt = mem_data;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_p0   <= RESET_PC;
         vld_p1        <= 1'b0;
         pc_p1         <= 32'd0;
         count_p2      <= 2'd0;
         vld_p2        <= 1'b0;
         head_pc_p2    <= 32'd0;
         head_instr_p2 <= 32'd0;
         tail_pc_p2    <= 32'd0;
         tail_instr_p2 <= 32'd0;
      end else if (redirect_valid) begin
         // Flush: the outstanding read and everything buffered belong to the old path.
         fetch_pc_p0   <= word_align(redirect_pc);
         vld_p1        <= 1'b0;
         count_p2      <= 2'd0;
         vld_p2        <= 1'b0;
         head_pc_p2    <= 32'd0;
         head_instr_p2 <= 32'd0;
         tail_pc_p2    <= 32'd0;
         tail_instr_p2 <= 32'd0;
      end else begin
         vld_p1 <= issue;
         if (issue) begin
            fetch_pc_p0 <= pc_incr(fetch_pc_p0);
            pc_p1       <= fetch_pc_p0;
         end
         count_p2      <= count_nxt;
         vld_p2        <= (count_nxt != 2'd0);
         head_pc_p2    <= head_pc_nxt;
         head_instr_p2 <= head_instr_nxt;
         tail_pc_p2    <= tail_pc_nxt;
         tail_instr_p2 <= tail_instr_nxt;
      end
   end

endmodule
